// File: rtl/uart_sim_transmitter.sv
// Buffered 8N1 UART transmitter: bytes enter a small FIFO through a valid/ready
// port and are serialised LSB first, back-to-back, on an idle-high txd_o line.
module uart_sim_transmitter #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 19200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       txd_o,
    output logic       busy_o
);

    localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int CW       = PW + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          push, pop, bit_end;

    // ready comes from the registered count only, so a full FIFO refuses a
    // push even on the cycle it is being popped.
    assign ready_o = (count_q != DEPTH_C);
    assign txd_o   = txd_q;
    assign busy_o  = busy_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        push       = valid_i && (count_q != DEPTH_C);
        bit_end    = (baud_cnt_q == BAUD_LAST);
        pop        = 1'b0;
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        txd_d      = txd_q;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    shift_d    = fifo_mem[rd_ptr_q];
                    baud_cnt_d = '0;
                    state_d    = START;
                    txd_d      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = DATA;
                    txd_d      = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // Next bit is driven straight from the unshifted copy.
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_sim_transmitter.sv
// Bench for uart_sim_transmitter: a line-level UART receiver model decodes txd_o
// and frames are checked against a queue of accepted bytes and expected timing.
module tb_uart_sim_transmitter;

    localparam int DIV      = 10;
    localparam int DIV_DEF  = 100000000 / 19200;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] data   = 8'h00;
    logic       valid  = 1'b0;
    logic [7:0] data2  = 8'h00;
    logic       valid2 = 1'b0;
    logic       ready, txd, busy;
    logic       ready2, txd2, busy2;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    uart_sim_transmitter #(
        .CLOCK_FREQ(1000000),
        .BAUD_RATE (100000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data),
        .valid_i(valid),
        .ready_o(ready),
        .txd_o  (txd),
        .busy_o (busy)
    );

    uart_sim_transmitter dut_def (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data2),
        .valid_i(valid2),
        .ready_o(ready2),
        .txd_o  (txd2),
        .busy_o (busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: waits for a start bit (sampled on negedges), then records
    // 10 bit periods of div cycles each and flags any change inside a bit.
    task automatic capture(input bit use2, input int div, input int timeout,
                           output logic [7:0] byte_o, output logic start_b,
                           output logic stop_b, output int start_cyc,
                           output bit stable, output bit timed_out);
        logic [9:0] fb;
        logic       v;
        fb        = '1;
        stable    = 1'b1;
        timed_out = 1'b1;
        start_cyc = 0;
        for (int t = 0; t < timeout; t++) begin
            @(negedge clk);
            v = use2 ? txd2 : txd;
            if (v === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (!timed_out) begin
            start_cyc = cyc;
            for (int j = 0; j < 10 * div; j++) begin
                if (j > 0) @(negedge clk);
                v = use2 ? txd2 : txd;
                if (j % div == 0) fb[j / div] = v;
                else if (v !== fb[j / div]) stable = 1'b0;
            end
        end
        byte_o  = fb[8:1];
        start_b = fb[0];
        stop_b  = fb[9];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (txd !== 1'b1) begin
            n_err++; $display("FAIL reset_txd: got %b want 1", txd);
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b want 1", ready);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (txd2 !== 1'b1 || busy2 !== 1'b0) begin
            n_err++; $display("FAIL reset_def: got txd=%b busy=%b want 1/0", txd2, busy2);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic [7:0] d, got;
        logic       sb, pb;
        int         n, st;
        bit         stable, to;
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 8'h4E : 8'($urandom);
            @(negedge clk);
            data = d; valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            valid = 1'b0;
            n = cyc;
            capture(1'b0, DIV, 50, got, sb, pb, st, stable, to);
            $display("single: byte %h sent at edge %0d, rx %h start %0d", d, n, got, st);
            n_cmp++;
            if (to || got !== d || sb !== 1'b0 || pb !== 1'b1 || !stable) begin
                n_err++;
                $display("FAIL single_frame: got %h start=%b stop=%b stable=%0d to=%0d want %h 0 1 1 0",
                         got, sb, pb, stable, to, d);
            end
            n_cmp++;
            if (st != n + 1) begin
                n_err++; $display("FAIL single_latency: got start %0d want %0d", st, n + 1);
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++; $display("FAIL single_busy_last: got %b want 1", busy);
            end
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || txd !== 1'b1 || ready !== 1'b1) begin
                n_err++;
                $display("FAIL single_end: got busy=%b txd=%b ready=%b want 0 1 1", busy, txd, ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [7];
        logic [7:0] got, want;
        logic       sb, pb;
        int         n0, st, prev, w;
        bit         stable, to;
        msg = '{8'h4E, 8'h45, 8'h4F, 8'h52, 8'h56, 8'h33, 8'h32};
        n0 = 0; prev = 0;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    data = msg[i]; valid = 1'b1;
                    w = 0;
                    while (ready !== 1'b1 && w < 200) begin
                        @(negedge clk); w++;
                    end
                    @(posedge clk);
                    exp_q.push_back(msg[i]);
                    @(negedge clk);
                    if (i == 0) n0 = cyc;
                end
                valid = 1'b0;
            end
            begin
                for (int i = 0; i < 7; i++) begin
                    capture(1'b0, DIV, 300, got, sb, pb, st, stable, to);
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    $display("b2b: frame %0d rx %h want %h start %0d", i, got, want, st);
                    n_cmp++;
                    if (to || got !== want || sb !== 1'b0 || pb !== 1'b1 || !stable) begin
                        n_err++;
                        $display("FAIL b2b_frame%0d: got %h stable=%0d to=%0d want %h", i, got, stable, to, want);
                    end
                    n_cmp++;
                    if ((i == 0 && st != n0 + 1) || (i > 0 && st != prev + 10 * DIV)) begin
                        n_err++;
                        $display("FAIL b2b_gap%0d: got start %0d want %0d", i, st,
                                 (i == 0) ? n0 + 1 : prev + 10 * DIV);
                    end
                    prev = st;
                end
            end
        join
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cyc != n0 + 1 + 7 * 10 * DIV) begin
            n_err++;
            $display("FAIL b2b_total: got busy=%b at %0d want 0 at %0d", busy, cyc, n0 + 1 + 70 * DIV);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] b, got, want;
        logic       sb, pb;
        int         n0, acc, st, prev, w;
        bit         stable, to;
        n0 = 0; acc = 0; prev = 0;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    b = 8'($urandom);
                    data = b; valid = 1'b1;
                    w = 0;
                    while (ready !== 1'b1 && w < 50) begin
                        @(negedge clk); w++;
                    end
                    @(posedge clk);
                    exp_q.push_back(b);
                    @(negedge clk);
                    if (i == 0) n0 = cyc;
                end
                n_cmp++;
                if (ready !== 1'b0) begin
                    n_err++; $display("FAIL full_ready: got %b want 0", ready);
                end
                data = 8'hAA;
                w = 0;
                while (ready !== 1'b1 && w < 300) begin
                    @(negedge clk); w++;
                end
                @(posedge clk);
                exp_q.push_back(8'hAA);
                @(negedge clk);
                acc = cyc;
                valid = 1'b0;
                $display("full: 0xAA accepted at edge %0d (first push %0d)", acc, n0);
                n_cmp++;
                if (acc != n0 + 10 * DIV + 2) begin
                    n_err++; $display("FAIL full_accept: got edge %0d want %0d", acc, n0 + 10 * DIV + 2);
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    capture(1'b0, DIV, 300, got, sb, pb, st, stable, to);
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    $display("full: frame %0d rx %h want %h start %0d", i, got, want, st);
                    n_cmp++;
                    if (to || got !== want || sb !== 1'b0 || pb !== 1'b1 || !stable) begin
                        n_err++;
                        $display("FAIL full_frame%0d: got %h stable=%0d to=%0d want %h", i, got, stable, to, want);
                    end
                    n_cmp++;
                    if ((i == 0 && st != n0 + 1) || (i > 0 && st != prev + 10 * DIV)) begin
                        n_err++; $display("FAIL full_gap%0d: got start %0d", i, st);
                    end
                    prev = st;
                end
            end
        join
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL full_end_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int         n0, bad;
        n0 = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            if (i == 0) b = b & 8'hF7;
            data = b; valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (i == 0) n0 = cyc;
        end
        valid = 1'b0;
        while (cyc < n0 + 1 + 4 * DIV + 4) @(negedge clk);
        n_cmp++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre: got txd=%b busy=%b want 0 1", txd, busy);
        end
        #2 rst = 1'b1;
        #1;
        $display("rstmid: reset asserted between edges at cycle %0d", cyc);
        n_cmp++;
        if (txd !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_async: got txd=%b busy=%b ready=%b want 1 0 1", txd, busy, ready);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_default_rate();
        logic [7:0] got;
        logic       sb, pb;
        int         n, st;
        bit         stable, to;
        @(negedge clk);
        data2 = 8'h55; valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid2 = 1'b0;
        n = cyc;
        capture(1'b1, DIV_DEF, 20, got, sb, pb, st, stable, to);
        $display("default: rx %h start %0d bit period %0d", got, st, DIV_DEF);
        n_cmp++;
        if (to || got !== 8'h55 || sb !== 1'b0 || pb !== 1'b1 || !stable) begin
            n_err++;
            $display("FAIL def_frame: got %h stable=%0d to=%0d want 55", got, stable, to);
        end
        n_cmp++;
        if (st != n + 1) begin
            n_err++; $display("FAIL def_latency: got start %0d want %0d", st, n + 1);
        end
        n_cmp++;
        if (busy2 !== 1'b1) begin
            n_err++; $display("FAIL def_busy_last: got %b want 1", busy2);
        end
        @(negedge clk);
        n_cmp++;
        if (busy2 !== 1'b0 || txd2 !== 1'b1) begin
            n_err++; $display("FAIL def_end: got busy=%b txd=%b want 0 1", busy2, txd2);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid();
        test_default_rate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
